serial_adder_acc: RTL
=====================

# serial_adder_acc

Parametrised bit-serial add/subtract/accumulate unit. It is the sequential successor to the single-bit half-adder datapath in the Tiny Tapeout top level. Operands arrive over a valid/ready handshake and are processed LSB-first, one bit per clock, through a single full-adder cell. The result is held under a valid/ready handshake until the consumer takes it.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32
- CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- in_valid  in  1  operand set valid
- in_ready  out  1  unit can accept operands (high only in IDLE)
- op_a  in  WIDTH  operand A
- op_b  in  WIDTH  operand B (ignored in ACC mode)
- mode  in  2  operation select: 00 ADD (A+B), 01 SUB (A−B), 10 ACC (acc+A), 11 reserved (executes as ADD)
- acc_clear  in  1  synchronous clear of the accumulator
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  sum/difference
- carry_out  out  1  final carry; for SUB, 1 = no borrow
- overflow  out  1  two's-complement signed overflow

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. If in_valid is high, latch op_a, op_b (or acc in place of B for ACC, with op_a as the other operand) and mode; clear the bit counter; go to RUN.
- Carry-in at launch: 1 for SUB, 0 otherwise. For SUB, B is inverted bitwise at latch time.
- RUN: each cycle, add operand bit [0] of both shift registers plus the carry register through full_adder_d.
  - Shift the sum bit into result MSB-side; shift operands right.
  - Counter increments each cycle.
  - When counter == WIDTH−1, go to DONE.
- overflow is computed on the final bit as carry into MSB XOR carry out of MSB.
- DONE: out_valid=1; result, carry_out and overflow are stable. Leave DONE when out_ready is high; then go to IDLE.
- Accumulator register (WIDTH bits, not a port) loads result on the RUN→DONE edge when mode=ACC.
- acc_clear: zeroes the accumulator on any cycle. If it coincides with an ACC load, the clear wins. An ACC operation already in RUN keeps the acc value latched at its launch.
- Arithmetic is modulo 2^WIDTH. There is no saturation.
- Reset: state=IDLE and all registers zeroed.
  - Outputs after reset: in_ready=1, out_valid=0, result=0, carry_out=0, overflow=0.
  - A reset during RUN or DONE abandons the operation; no result is produced.

## Timing
- Handshake rules:
  - Acceptance occurs on an edge with in_valid && in_ready.
  - Delivery occurs on an edge with out_valid && out_ready.
- Latency: out_valid rises exactly WIDTH edges after the accepting edge.
- There is no bypass. After delivery, in_ready goes high the following cycle. Throughput is one operation per WIDTH+2 cycles when out_ready is held high.
- in_ready is combinational from state only; it does not depend on in_valid.
- result, carry_out and overflow are registered. They hold their last value outside DONE; only out_valid qualifies them.
- Under backpressure (out_ready low), the unit stays in DONE indefinitely with outputs frozen.
- Inputs op_a, op_b and mode are sampled only on the accepting edge. Changes during RUN have no effect.

## Structure
- Package serial_adder_pkg holds:
  - mode constants MODE_ADD, MODE_SUB, MODE_ACC, MODE_RSV
  - state enum state_t {IDLE, RUN, DONE}
- Sub-module full_adder_d: purely combinational; inputs a, b, cin; outputs sum, cout. It is built from two half_adder_d cells plus an OR, and is instantiated once.
- Top datapath: operand shift registers, result shift register, carry flop, bit counter, accumulator.

## Test plan
All scenarios use WIDTH=8.
- Reset, then ADD 0x0F+0x01 → after 8 edges: out_valid=1, result=0x10, carry_out=0, overflow=0.
- ADD 0xFF+0x01 → result=0x00, carry_out=1, overflow=0. ADD 0x7F+0x01 → result=0x80, overflow=1.
- SUB 0x05−0x07 → result=0xFE, carry_out=0, overflow=0. SUB 0x80−0x01 → result=0x7F, overflow=1.
- ACC sequence 0x10, 0x20, 0x30 from a cleared accumulator → results 0x10, 0x30, 0x60. Then assert acc_clear, then ACC 0x05 → result 0x05.
- Backpressure: out_ready low for 5 cycles in DONE → out_valid, result and in_ready=0 held constant. When out_ready goes high, in_ready rises the next cycle. Operands changed during RUN do not alter the result.
- Assert rst_n low mid-RUN (bit 3), then release → in_ready=1, out_valid=0, result=0. The next ADD 0x01+0x02 returns 0x03.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared mode encodings and FSM state type for the bit-serial add/sub/accumulate unit.
package serial_adder_pkg;

   localparam logic [1:0] MODE_ADD = 2'b00;
   localparam logic [1:0] MODE_SUB = 2'b01;
   localparam logic [1:0] MODE_ACC = 2'b10;
   localparam logic [1:0] MODE_RSV = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

endpackage

// File: rtl/full_adder_d.sv
// Combinational full adder built from two half adders and an OR of their carries.
module full_adder_d (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   logic w_s0;
   logic w_c0;
   logic w_c1;

   half_adder_d u_ha0 (
      .a     (a),
      .b     (b),
      .sum   (w_s0),
      .carry (w_c0)
   );

   half_adder_d u_ha1 (
      .a     (w_s0),
      .b     (cin),
      .sum   (sum),
      .carry (w_c1)
   );

   assign cout = w_c0 | w_c1;

endmodule

// File: rtl/half_adder_d.sv
// Single-bit half adder; building block of full_adder_d.
module half_adder_d (
   input  logic a,
   input  logic b,
   output logic sum,
   output logic carry
);

   assign sum   = a ^ b;
   assign carry = a & b;

endmodule

// File: rtl/serial_adder_acc.sv
// Bit-serial ADD/SUB/ACC unit: LSB-first through one full adder, valid/ready on both sides.
module serial_adder_acc
   import serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic [1:0]       mode,
   input  logic             acc_clear,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow
);

   localparam int unsigned CNT_W = $clog2(WIDTH);

   state_t             r_state;
   state_t             w_next_state;
   logic               w_accept;
   logic               w_last;

   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH-1:0]   r_shift;
   logic [WIDTH-1:0]   r_result;
   logic [WIDTH-1:0]   r_acc;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_carry;
   logic               r_cout;
   logic               r_ovf;
   logic               r_is_acc;

   logic               w_sum;
   logic               w_cout;
   logic [WIDTH-1:0]   w_shift_next;

   full_adder_d u_fa (
      .a    (r_a[0]),
      .b    (r_b[0]),
      .cin  (r_carry),
      .sum  (w_sum),
      .cout (w_cout)
   );

   assign w_shift_next = {w_sum, r_shift[WIDTH-1:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      w_last       = 1'b0;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_accept     = 1'b1;
               w_next_state = RUN;
            end
         end
         RUN: begin
            if (r_cnt == CNT_W'(WIDTH - 1)) begin
               w_last       = 1'b1;
               w_next_state = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               w_next_state = IDLE;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   // Operand latch at launch, then one bit per RUN cycle; results captured on the last bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a      <= '0;
         r_b      <= '0;
         r_shift  <= '0;
         r_result <= '0;
         r_cnt    <= '0;
         r_carry  <= 1'b0;
         r_cout   <= 1'b0;
         r_ovf    <= 1'b0;
         r_is_acc <= 1'b0;
      end else if (w_accept) begin
         r_a      <= op_a;
         case (mode)
            MODE_SUB: r_b <= ~op_b;
            MODE_ACC: r_b <= r_acc;
            default:  r_b <= op_b;
         endcase
         r_carry  <= (mode == MODE_SUB);
         r_is_acc <= (mode == MODE_ACC);
         r_cnt    <= '0;
      end else if (r_state == RUN) begin
         r_a     <= r_a >> 1;
         r_b     <= r_b >> 1;
         r_shift <= w_shift_next;
         r_carry <= w_cout;
         r_cnt   <= r_cnt + CNT_W'(1);
         if (w_last) begin
            r_result <= w_shift_next;
            r_cout   <= w_cout;
            r_ovf    <= r_carry ^ w_cout;
         end
      end
   end

   // Clear has priority over an accumulate write-back landing on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc <= '0;
      end else if (acc_clear) begin
         r_acc <= '0;
      end else if (w_last && r_is_acc) begin
         r_acc <= w_shift_next;
      end
   end

   assign result    = r_result;
   assign carry_out = r_cout;
   assign overflow  = r_ovf;

endmodule
